// File: rtl/tag_alloc_pkg.sv
// Shared types and constants for the free-tag allocator and its priority encoder.
package tag_alloc_pkg;

  localparam int TAG_W    = 7;
  localparam int MAX_TAGS = 96;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [MAX_TAGS-1:0] tag_map_t;

  localparam tag_t NO_TAG = 7'd96;

  // Bitmap with the low n tags free; bits at or above n stay zero.
  function automatic tag_map_t reset_map(input int n);
    tag_map_t m;
    m = '0;
    for (int i = 0; i < MAX_TAGS; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/tag_alloc_96_pri_enc.sv
// Registered 96:7 lowest-set-bit encoder; dout is NO_TAG when din is empty.
// One cycle latency, no reset on the output register.
module pri_enc_96_7
  import tag_alloc_pkg::*;
#(
  parameter bit SIM_EMULATE = 1'b0
) (
  input  logic     clk,
  input  tag_map_t din,
  output tag_t     dout
);

  tag_t dout_d, dout_q;

  if (SIM_EMULATE) begin : g_emu
    always_comb begin
      dout_d = NO_TAG;
      for (int i = MAX_TAGS - 1; i >= 0; i--)
        if (din[i]) dout_d = tag_t'(i);
    end
  end else begin : g_tree
    // Two-level search: lowest bit inside each byte, then lowest non-empty byte.
    logic [11:0]      grp_any;
    logic [11:0][2:0] grp_low;

    always_comb begin
      grp_any = '0;
      grp_low = '0;
      dout_d  = NO_TAG;
      for (int g = 0; g < 12; g++) begin
        grp_any[g] = |din[g*8 +: 8];
        for (int b = 7; b >= 0; b--)
          if (din[g*8 + b]) grp_low[g] = 3'(b);
      end
      for (int g = 11; g >= 0; g--)
        if (grp_any[g]) dout_d = {4'(g), grp_low[g]};
    end
  end

  always_ff @(posedge clk) dout_q <= dout_d;

  assign dout = dout_q;

endmodule

// File: rtl/tag_alloc_96.sv
// Free-tag allocator: keeps a free bitmap, presents the lowest free tag on a
// valid/ready port and accepts tag returns on a release port.
module tag_alloc_96
  import tag_alloc_pkg::*;
#(
  parameter int NUM_TAGS    = 96,
  parameter bit SIM_EMULATE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic tag_valid,
  input  logic tag_ready,
  output tag_t tag_out,
  input  logic rel_valid,
  input  tag_t rel_tag,
  output tag_t free_count,
  output logic rel_err
);

  localparam tag_map_t VALID_MASK  = reset_map(NUM_TAGS);
  localparam tag_t     NUM_TAGS_T  = tag_t'(NUM_TAGS);

  tag_map_t free_map_d, free_map_q;
  logic     tag_valid_d, tag_valid_q;
  tag_t     tag_out_d, tag_out_q;
  tag_t     free_count_d, free_count_q;
  logic     rel_err_d, rel_err_q;
  logic     enc_ok_d, enc_ok_q;

  tag_t     enc;
  tag_map_t enc_din;
  tag_map_t clr_mask, set_mask;
  logic     load, rel_free, rel_legal;

  // Encoder sees next-state map, so its registered output tracks free_map_q.
  pri_enc_96_7 #(.SIM_EMULATE(SIM_EMULATE)) u_enc (
    .clk  (clk),
    .din  (enc_din),
    .dout (enc)
  );

  always_comb begin
    load      = enc_ok_q && (enc != NO_TAG) && (!tag_valid_q || tag_ready);
    rel_free  = |(free_map_q & (tag_map_t'(1) << rel_tag));
    rel_legal = rel_valid && (rel_tag < NUM_TAGS_T) && !rel_free &&
                !(tag_valid_q && (rel_tag == tag_out_q));

    clr_mask  = load      ? (tag_map_t'(1) << enc)     : '0;
    set_mask  = rel_legal ? (tag_map_t'(1) << rel_tag) : '0;
    free_map_d = ((free_map_q & ~clr_mask) | set_mask) & VALID_MASK;

    tag_valid_d = tag_valid_q;
    tag_out_d   = tag_out_q;
    if (load) begin
      tag_valid_d = 1'b1;
      tag_out_d   = enc;
    end else if (tag_valid_q && tag_ready) begin
      tag_valid_d = 1'b0;
    end

    free_count_d = free_count_q + tag_t'(rel_legal) - tag_t'(load);
    rel_err_d    = rel_err_q | (rel_valid && !rel_legal);
    enc_ok_d     = 1'b1;

    enc_din = rst ? VALID_MASK : free_map_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map_q   <= VALID_MASK;
      tag_valid_q  <= 1'b0;
      tag_out_q    <= '0;
      free_count_q <= NUM_TAGS_T;
      rel_err_q    <= 1'b0;
      enc_ok_q     <= 1'b0;
    end else begin
      free_map_q   <= free_map_d;
      tag_valid_q  <= tag_valid_d;
      tag_out_q    <= tag_out_d;
      free_count_q <= free_count_d;
      rel_err_q    <= rel_err_d;
      enc_ok_q     <= enc_ok_d;
    end
  end

  assign tag_valid  = tag_valid_q;
  assign tag_out    = tag_out_q;
  assign free_count = free_count_q;
  assign rel_err    = rel_err_q;

endmodule

// File: tb/tb_tag_alloc_96.sv
// Scoreboard bench for tag_alloc_96: stimulus pushes expected tags, monitors
// pop and compare on every handshake; directed checks cover counts and errors.
module tb_tag_alloc_96;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       tag_valid, tag_ready, rel_valid, rel_err;
  logic [6:0] tag_out, rel_tag, free_count;

  logic       tag_valid4, tag_ready4, rel_err4;
  logic [6:0] tag_out4, free_count4;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int exp_q4[$];

  tag_alloc_96 #(.NUM_TAGS(96), .SIM_EMULATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .tag_out(tag_out), .rel_valid(rel_valid), .rel_tag(rel_tag),
    .free_count(free_count), .rel_err(rel_err)
  );

  tag_alloc_96 #(.NUM_TAGS(4), .SIM_EMULATE(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .tag_valid(tag_valid4), .tag_ready(tag_ready4),
    .tag_out(tag_out4), .rel_valid(1'b0), .rel_tag(7'd0),
    .free_count(free_count4), .rel_err(rel_err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      tick();
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk)
    if (tag_valid === 1'b1 && tag_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("tag_unexpected", tag_out, 999);
      else                   chk("tag_seq", tag_out, exp_q.pop_front());
    end

  always @(negedge clk)
    if (tag_valid4 === 1'b1 && tag_ready4 === 1'b1) begin
      if (exp_q4.size() == 0) chk("tag4_unexpected", tag_out4, 999);
      else                    chk("tag4_seq", tag_out4, exp_q4.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d tests so far", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tag_ready  = 1'b1;
    rel_valid  = 1'b0;
    rel_tag    = '0;
    tag_ready4 = 1'b0;
    tick(); tick();
    chk("rst_valid", tag_valid, 0);
    chk("rst_tag_out", tag_out, 0);
    chk("rst_free_count", free_count, 96);
    chk("rst_rel_err", rel_err, 0);
    chk("rst4_free_count", free_count4, 4);

    // Full drain with ready held high: 0..95 back to back.
    for (int i = 0; i < 96; i++) exp_q.push_back(i);
    rst = 1'b0;
    fork
      begin
        tick(); chk("valid_edge1", tag_valid, 0);
        tick(); chk("valid_edge2", tag_valid, 1);
        chk("first_tag", tag_out, 0);
        chk("first_free_count", free_count, 95);
        wait_drain(200);
        chk("empty_valid", tag_valid, 0);
        chk("empty_free_count", free_count, 0);
      end
      begin
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
          chk("hold4_valid", tag_valid4, 1);
          chk("hold4_tag", tag_out4, 0);
          chk("hold4_free_count", free_count4, 3);
          tick();
        end
        for (int i = 0; i < 4; i++) exp_q4.push_back(i);
        tag_ready4 = 1'b1;
        repeat (6) tick();
        chk("drain4_valid", tag_valid4, 0);
        chk("drain4_free_count", free_count4, 0);
        chk("drain4_pending", exp_q4.size(), 0);
        tag_ready4 = 1'b0;
      end
    join

    // Release into an empty allocator.
    exp_q.push_back(37);
    rel_valid = 1'b1; rel_tag = 7'd37;
    tick();
    rel_valid = 1'b0;
    chk("rel37_free_count", free_count, 1);
    chk("rel37_valid_early", tag_valid, 0);
    tick();
    chk("rel37_valid", tag_valid, 1);
    chk("rel37_tag", tag_out, 37);
    chk("rel37_free_after", free_count, 0);
    tick();
    chk("rel37_done", tag_valid, 0);
    chk("rel37_pending", exp_q.size(), 0);

    // Steady state: consume 5 while releasing 2.
    tag_ready = 1'b0;
    rel_valid = 1'b1; rel_tag = 7'd5; tick();
    rel_tag = 7'd6; tick();
    rel_tag = 7'd7; tick();
    rel_valid = 1'b0;
    tick(); tick();
    chk("held_tag5", tag_out, 5);
    chk("held_free_count", free_count, 2);
    exp_q.push_back(5); exp_q.push_back(6);
    exp_q.push_back(2); exp_q.push_back(7);
    tag_ready = 1'b1;
    rel_valid = 1'b1; rel_tag = 7'd2;
    tick();
    rel_valid = 1'b0;
    chk("swap_tag", tag_out, 6);
    chk("swap_free_count", free_count, 2);
    wait_drain(20);
    chk("swap_empty_valid", tag_valid, 0);
    chk("swap_empty_count", free_count, 0);

    // Illegal releases.
    tag_ready = 1'b0;
    rel_valid = 1'b1; rel_tag = 7'd9; tick();
    rel_tag = 7'd10; tick();
    rel_valid = 1'b0;
    chk("legal_rel_err", rel_err, 0);
    chk("ill_setup_tag", tag_out, 9);
    chk("ill_setup_count", free_count, 1);
    rel_valid = 1'b1; rel_tag = 7'd10; tick();
    rel_valid = 1'b0;
    chk("ill_free_err", rel_err, 1);
    chk("ill_free_count", free_count, 1);
    rel_valid = 1'b1; rel_tag = 7'd100; tick();
    rel_valid = 1'b0;
    chk("ill_range_count", free_count, 1);
    rel_valid = 1'b1; rel_tag = 7'd9; tick();
    rel_valid = 1'b0;
    chk("ill_held_count", free_count, 1);
    chk("ill_held_tag", tag_out, 9);
    chk("ill_sticky_err", rel_err, 1);

    // Reset clears errors, then allocate 40 and reset mid-stream.
    rst = 1'b1; tick(); tick();
    chk("rst2_rel_err", rel_err, 0);
    chk("rst2_free_count", free_count, 96);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) exp_q.push_back(i);
    tag_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    tag_ready = 1'b0;
    chk("alloc40_pending", exp_q.size(), 0);
    chk("alloc40_held", tag_out, 40);
    chk("alloc40_count", free_count, 55);
    rst = 1'b1; tick();
    chk("midrst_valid", tag_valid, 0);
    chk("midrst_tag", tag_out, 0);
    chk("midrst_count", free_count, 96);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tag_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    tag_ready = 1'b0;
    chk("restart_pending", exp_q.size(), 0);
    chk("restart_held", tag_out, 4);
    chk("restart_count", free_count, 91);
    chk("restart_rel_err", rel_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
